// File: rtl/vp_pkg.sv
// Shared definitions for the vector processor instruction path:
// instruction word layout, opcode values and sequencer state encoding.
package vp_pkg;

  localparam int INST_W = 9;

  localparam logic [1:0] OP_LOADS  = 2'b00;
  localparam logic [1:0] OP_OUTR   = 2'b01;
  localparam logic [1:0] OP_LOADD2 = 2'b10;
  localparam logic [1:0] OP_LOADD  = 2'b11;

  localparam int OP_MSB   = 8;
  localparam int OP_LSB   = 7;
  localparam int REG_MSB  = 6;
  localparam int REG_LSB  = 5;
  localparam int ADDR_MSB = 4;
  localparam int ADDR_LSB = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/vp_prog_buffer.sv
// Program storage: DEPTH x INST_W words, synchronous write, combinational read.
// Contents are deliberately not reset so a program survives a core reset.
module vp_prog_buffer
  import vp_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem_r [DEPTH];

  // Storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/vp_instruction_sequencer.sv
// Streams a buffered vector program into the core, one instruction per clock,
// with host hold/abort. The last issued word is re-driven while not issuing.
module vp_instruction_sequencer
  import vp_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [INST_W-1:0] prog_data,
  input  logic              start,
  input  logic [AW:0]       prog_len,
  input  logic              hold,
  input  logic              abort,
  output logic [INST_W-1:0] instruction,
  output logic              issue_valid,
  output logic [AW:0]       pc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  seq_state_t        state_r, state_s;
  logic [AW:0]       len_r, len_s;
  logic [AW:0]       pc_r, pc_s;
  logic [INST_W-1:0] inst_r, inst_s;
  logic              iv_r, iv_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic              we_s;
  logic              len_ok_s;
  logic [AW-1:0]     raddr_s;
  logic [INST_W-1:0] rdata_s;

  // In IDLE the read port sits on entry 0 so start can issue it without a bubble
  assign raddr_s  = (state_r == ST_RUN) ? pc_r[AW-1:0] : {AW{1'b0}};
  assign len_ok_s = (prog_len != {(AW+1){1'b0}}) && (prog_len <= DEPTH_L);

  vp_prog_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (we_s),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Next-state and next-output decode
  always_comb begin
    state_s = state_r;
    len_s   = len_r;
    pc_s    = pc_r;
    inst_s  = inst_r;
    iv_s    = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
    we_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        we_s = prog_we;
        if (start) begin
          if (len_ok_s) begin
            len_s   = prog_len;
            inst_s  = rdata_s;
            iv_s    = 1'b1;
            pc_s    = {{AW{1'b0}}, 1'b1};
            state_s = ST_RUN;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        err_s = prog_we | start;
        if (abort) begin
          state_s = ST_IDLE;
        end else if (hold) begin
          iv_s = 1'b0;
        end else if (pc_r == len_r) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          inst_s = rdata_s;
          iv_s   = 1'b1;
          pc_s   = pc_r + {{AW{1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      len_r   <= {(AW+1){1'b0}};
      pc_r    <= {(AW+1){1'b0}};
      inst_r  <= {INST_W{1'b0}};
      iv_r    <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      len_r   <= len_s;
      pc_r    <= pc_s;
      inst_r  <= inst_s;
      iv_r    <= iv_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  assign instruction = inst_r;
  assign issue_valid = iv_r;
  assign pc          = pc_r;
  assign busy        = (state_r == ST_RUN);
  assign done        = done_r;
  assign err         = err_r;

endmodule

// File: tb/tb_vp_instruction_sequencer.sv
// Directed, table-driven bench for vp_instruction_sequencer with hand-computed
// expectations, plus hand sequences for reset mid-run and the full-depth run.
module tb_vp_instruction_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [8:0] prog_data;
  logic       start;
  logic [5:0] prog_len;
  logic       hold;
  logic       abort;
  logic [8:0] instruction;
  logic       issue_valid;
  logic [5:0] pc;
  logic       busy;
  logic       done;
  logic       err;

  int tests  = 0;
  int failed = 0;

  logic [8:0] mem_m [32];

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [8:0]  data;
    logic        st;
    logic [5:0]  len;
    logic        hold;
    logic        abort;
    logic [18:0] exp;
  } vec_t;

  vec_t vq[$];

  vp_instruction_sequencer #(.DEPTH(32), .AW(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .prog_len    (prog_len),
    .hold        (hold),
    .abort       (abort),
    .instruction (instruction),
    .issue_valid (issue_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] pk(logic [8:0] ins, logic iv, logic [5:0] p,
                                     logic b, logic d, logic e);
    return {ins, iv, p, b, d, e};
  endfunction

  function automatic vec_t mk(logic we, logic [4:0] a, logic [8:0] dt, logic st,
                              logic [5:0] len, logic h, logic ab, logic [18:0] exp);
    vec_t v;
    v.we = we; v.addr = a; v.data = dt; v.st = st; v.len = len;
    v.hold = h; v.abort = ab; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [18:0] exp);
    logic [18:0] got;
    got = {instruction, issue_valid, pc, busy, done, err};
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got ins=%h iv=%b pc=%0d busy=%b done=%b err=%b, want ins=%h iv=%b pc=%0d busy=%b done=%b err=%b",
               name, got[18:10], got[9], got[8:3], got[2], got[1], got[0],
               exp[18:10], exp[9], exp[8:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic idle_inputs();
    prog_we = 1'b0; prog_addr = 5'd0; prog_data = 9'h000;
    start = 1'b0; prog_len = 6'd0; hold = 1'b0; abort = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem_m[i] = 9'((i * 37 + 5) ^ 9'h0AA);
    end
    mem_m[0] = 9'h1A3; mem_m[1] = 9'h0C5; mem_m[2] = 9'h180;

    // Program: plain 3-run
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b1, 6'd3, 1'b0, 1'b0, pk(9'h1A3, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h0C5, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h180, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h180, 1'b0, 6'd3, 1'b0, 1'b1, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h180, 1'b0, 6'd3, 1'b0, 1'b0, 1'b0)));
    // Hold for two cycles after first issue
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b1, 6'd3, 1'b0, 1'b0, pk(9'h1A3, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b1, 1'b0, pk(9'h1A3, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b1, 1'b0, pk(9'h1A3, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h0C5, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h180, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h180, 1'b0, 6'd3, 1'b0, 1'b1, 1'b0)));
    // Abort after second issue, then a 1-run
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b1, 6'd3, 1'b0, 1'b0, pk(9'h1A3, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h0C5, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b1, 1'b1, pk(9'h0C5, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h0C5, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b1, 6'd1, 1'b0, 1'b0, pk(9'h1A3, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h1A3, 1'b0, 6'd1, 1'b0, 1'b1, 1'b0)));
    // Illegal lengths
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b1, 6'd0, 1'b0, 1'b0, pk(9'h1A3, 1'b0, 6'd1, 1'b0, 1'b0, 1'b1)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h1A3, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b1, 6'd33, 1'b0, 1'b0, pk(9'h1A3, 1'b0, 6'd1, 1'b0, 1'b0, 1'b1)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h1A3, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0)));
    // Write during RUN is rejected
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b1, 6'd2, 1'b0, 1'b0, pk(9'h1A3, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b1, 5'd1, 9'h0FF, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h0C5, 1'b1, 6'd2, 1'b1, 1'b0, 1'b1)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h0C5, 1'b0, 6'd2, 1'b0, 1'b1, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b1, 6'd2, 1'b0, 1'b0, pk(9'h1A3, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h0C5, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h0C5, 1'b0, 6'd2, 1'b0, 1'b1, 1'b0)));
    // Start and write to address 0 on the same edge: old word issues, write lands
    vq.push_back(mk(1'b1, 5'd0, 9'h111, 1'b1, 6'd1, 1'b0, 1'b0, pk(9'h1A3, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h1A3, 1'b0, 6'd1, 1'b0, 1'b1, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b1, 6'd1, 1'b0, 1'b0, pk(9'h111, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h111, 1'b0, 6'd1, 1'b0, 1'b1, 1'b0)));
    // start during RUN is rejected
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b1, 6'd2, 1'b0, 1'b0, pk(9'h111, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b1, 6'd2, 1'b0, 1'b0, pk(9'h0C5, 1'b1, 6'd2, 1'b1, 1'b0, 1'b1)));
    vq.push_back(mk(1'b0, 5'd0, 9'h000, 1'b0, 6'd0, 1'b0, 1'b0, pk(9'h0C5, 1'b0, 6'd2, 1'b0, 1'b1, 1'b0)));

    #12;
    check("reset_state", pk(9'h000, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      prog_we = 1'b1; prog_addr = 5'(i); prog_data = mem_m[i];
      @(posedge clk); #1;
    end
    idle_inputs();
    check("after_load", pk(9'h000, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < vq.size(); i++) begin
      prog_we = vq[i].we; prog_addr = vq[i].addr; prog_data = vq[i].data;
      start = vq[i].st; prog_len = vq[i].len; hold = vq[i].hold; abort = vq[i].abort;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vq[i].exp);
    end
    idle_inputs();
    mem_m[0] = 9'h111;

    // Reset in the middle of a full-depth run
    start = 1'b1; prog_len = 6'd32;
    @(posedge clk); #1;
    idle_inputs();
    check("mid_first", pk(mem_m[0], 1'b1, 6'd1, 1'b1, 1'b0, 1'b0));
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("mid_issue%0d", k), pk(mem_m[k], 1'b1, 6'(k + 1), 1'b1, 1'b0, 1'b0));
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", pk(9'h000, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    check("held_reset", pk(9'h000, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;

    // Full replay of the retained buffer up to pc == DEPTH
    start = 1'b1; prog_len = 6'd32;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      idle_inputs();
      check($sformatf("full_issue%0d", k), pk(mem_m[k], 1'b1, 6'(k + 1), 1'b1, 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    check("full_done", pk(mem_m[31], 1'b0, 6'd32, 1'b0, 1'b1, 1'b0));
    @(posedge clk); #1;
    check("full_after", pk(mem_m[31], 1'b0, 6'd32, 1'b0, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
